phase_sequencer: RTL
====================

// Module: phase_sequencer
// PURPOSE
//  Upstream timing/fetch stage of the 8-bit accumulator CPU. Generates the 3-bit
//  instruction phase (0..7) and holds the instruction register (opcode + operand
//  address) that feed the opcode decoder/controller. Consumes the controller's
//  rd/ld_ir/halt strobes, inserts memory wait states, and implements the halted
//  state with resume.
// PARAMETERS
//  DWIDTH    8   instruction/data word width; opcode = ir[DWIDTH-1 -: 3]
//  AWIDTH    5   operand address width; ir_addr = ir[AWIDTH-1:0]; DWIDTH == AWIDTH+3
//  WAIT_MAX  15  max consecutive stall cycles before bus_err; 1..255
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous, active-high reset
//  rd        in   1       memory read strobe from controller
//  ld_ir     in   1       instruction-register load strobe from controller
//  halt      in   1       halt strobe from controller (HLT, phase 4)
//  mem_rdy   in   1       memory data valid; 0 = insert wait state
//  data_in   in   DWIDTH  memory read data
//  resume    in   1       leave HALTED (single-cycle pulse)
//  phase     out  3       current phase to controller
//  opcode    out  3       ir[DWIDTH-1:DWIDTH-3]
//  ir_addr   out  AWIDTH  ir[AWIDTH-1:0]
//  running   out  1       1 in RUN, 0 otherwise
//  bus_err   out  1       sticky memory-timeout flag
// BEHAVIOUR
//  Reset (async, immediate): phase=0, ir=0, wait_cnt=0, state=RUN, running=1, bus_err=0.
//  FSM states: RUN, HALTED (+STEP_WAIT, see CONFIGURATION).
//  stall = rd & ~mem_rdy (combinational).
//  RUN:
//   - stall=0: phase <= phase+1, wraps 7->0; wait_cnt <= 0.
//   - stall=1: phase holds; wait_cnt <= wait_cnt+1. When wait_cnt == WAIT_MAX-1 and
//     still stalled: bus_err <= 1, state <= HALTED, phase holds.
//   - halt=1 (and stall=0): state <= HALTED, phase holds at its current value (4).
//   - halt has priority over normal advance; stall and halt together never occur
//     (rd=0 at phase 4); if they do, halt wins.
//  HALTED: phase, ir frozen; running=0.
//   - resume=1 & bus_err=0: phase <= phase+1 (4->5), state <= RUN, wait_cnt <= 0.
//   - resume ignored while bus_err=1; only rst clears bus_err.
//   - halt input ignored in HALTED and in the resume cycle.
//  resume in RUN: ignored.
//  IR: ir <= data_in on a rising edge with ld_ir=1 & stall=0 & state==RUN; otherwise holds.
//   Captured value visible on opcode/ir_addr the next cycle; ld_ir in phases 2 and 3
//   reloads the same word (harmless).
//  wait_cnt: 8 bits, saturates at WAIT_MAX; never wraps.
//  All outputs registered or direct slices of registers; no comb path input->output.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds inputs step_mode (1) and step (1), state STEP_WAIT.
//   - RUN, phase 7 advancing to 0 with step_mode=1: phase <= 0, state <= STEP_WAIT,
//     running=0.
//   - STEP_WAIT: phase held at 0; step=1 -> state <= RUN, phase <= 1 next edge.
//   - step_mode deasserted in STEP_WAIT -> RUN next edge (no step needed).
//   - halt/bus_err behaviour unchanged; step ignored in RUN and HALTED.
//  SINGLE_STEP_EN undefined: ports and state absent; 7->0 wrap always continues.
// TESTING
//  1 rst pulse mid-run (phase=5) -> phase=0, opcode=0, running=1, bus_err=0 same cycle.
//  2 mem_rdy=1, rd/ld_ir as controller drives, data_in=8'hA3 at phase 2 ->
//    phase 0..7 one per clk, opcode=3'b101, ir_addr=5'h03 from phase 3.
//  3 rd=1, mem_rdy=0 for 3 cycles at phase 1 -> phase stays 1 for 3 extra clks,
//    then advances to 2; bus_err=0.
//  4 rd=1, mem_rdy held 0 for WAIT_MAX cycles -> bus_err=1, running=0;
//    resume ignored; rst clears.
//  5 halt=1 at phase 4 -> phase frozen at 4, running=0 for 10 clks;
//    resume pulse -> phase=5, running=1.
//  6 (SINGLE_STEP_EN) step_mode=1 -> after phase 7, phase=0 held; step pulse ->
//    phases 1..7 then hold at 0 again.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// Fetch-stage bus between the accumulator-CPU controller and phase_sequencer.
// Carries step_mode/step only when SINGLE_STEP_EN is defined.
interface phase_sequencer_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
);
  logic              rd;
  logic              ld_ir;
  logic              halt;
  logic              mem_rdy;
  logic [DWIDTH-1:0] data_in;
  logic              resume;
`ifdef SINGLE_STEP_EN
  logic              step_mode;
  logic              step;
`endif
  logic [2:0]        phase;
  logic [2:0]        opcode;
  logic [AWIDTH-1:0] ir_addr;
  logic              running;
  logic              bus_err;

`ifdef SINGLE_STEP_EN
  modport master (output rd, ld_ir, halt, mem_rdy, data_in, resume, step_mode, step,
                  input  phase, opcode, ir_addr, running, bus_err);
  modport slave  (input  rd, ld_ir, halt, mem_rdy, data_in, resume, step_mode, step,
                  output phase, opcode, ir_addr, running, bus_err);
`else
  modport master (output rd, ld_ir, halt, mem_rdy, data_in, resume,
                  input  phase, opcode, ir_addr, running, bus_err);
  modport slave  (input  rd, ld_ir, halt, mem_rdy, data_in, resume,
                  output phase, opcode, ir_addr, running, bus_err);
`endif
endinterface

// File: rtl/phase_sequencer.sv
// Instruction phase generator and instruction register for the 8-bit accumulator CPU,
// with memory wait states, halt/resume and bus timeout. Optional: SINGLE_STEP_EN.
module phase_sequencer #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  phase_sequencer_if.slave   bus
);

`ifdef SINGLE_STEP_EN
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALTED    = 2'd1,
    ST_STEP_WAIT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1
  } state_t;
`endif

  localparam logic [7:0] WAIT_MAX_C  = WAIT_MAX[7:0];
  localparam logic [7:0] WAIT_LAST_C = 8'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [7:0]        wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  logic              running_q;
  logic              stall_s;

  assign stall_s = bus.rd & ~bus.mem_rdy;

  // Next-state, phase, wait counter and instruction register
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    ir_d      = ir_q;

    if (bus.ld_ir && !stall_s && (state_q == ST_RUN)) begin
      ir_d = bus.data_in;
    end else begin
      ir_d = ir_q;
    end

    case (state_q)
      ST_RUN: begin
        if (bus.halt) begin
          state_d = ST_HALTED;
        end else if (stall_s) begin
          wait_d = (wait_q == WAIT_MAX_C) ? wait_q : wait_q + 8'd1;
          // Timeout: the stall that would reach WAIT_MAX cycles parks the CPU
          if (wait_q == WAIT_LAST_C) begin
            bus_err_d = 1'b1;
            state_d   = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          wait_d = 8'd0;
`ifdef SINGLE_STEP_EN
          if ((phase_q == 3'd7) && bus.step_mode) begin
            phase_d = 3'd0;
            state_d = ST_STEP_WAIT;
          end else begin
            phase_d = phase_q + 3'd1;
          end
`else
          phase_d = phase_q + 3'd1;
`endif
        end
      end
      ST_HALTED: begin
        if (bus.resume && !bus_err_q) begin
          phase_d = phase_q + 3'd1;
          state_d = ST_RUN;
          wait_d  = 8'd0;
        end else begin
          state_d = ST_HALTED;
        end
      end
`ifdef SINGLE_STEP_EN
      ST_STEP_WAIT: begin
        if (!bus.step_mode) begin
          state_d = ST_RUN;
        end else if (bus.step) begin
          phase_d = 3'd1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      phase_q   <= 3'd0;
      ir_q      <= '0;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign bus.phase   = phase_q;
  assign bus.opcode  = ir_q[DWIDTH-1 -: 3];
  assign bus.ir_addr = ir_q[AWIDTH-1:0];
  assign bus.running = running_q;
  assign bus.bus_err = bus_err_q;

endmodule
